irig_edge_meas: RTL and testbench

Multi-channel IRIG front-end conditioner: each channel synchronises a raw IRIG level input and glitch-filters it. It then tracks the filtered level with a 4-state FSM. Outputs per channel are a one-clock edge pulse (rising, falling, both or none, selectable at run time) and the measured high-time width of every pulse in clock cycles. It sits between the IRIG input pins and the bit decoder, which classifies 0/1/marker symbols from `width`.

---
 rtl/irig_pkg.sv | 18 +
 rtl/irig_edge_chan.sv | 105 ++++++++++
 rtl/irig_edge_meas.sv | 39 +++
 tb/tb_irig_edge_meas.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/irig_pkg.sv
// Shared encodings for the IRIG edge/width front end.
package irig_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'b00,
        S_RISE = 2'b01,
        S_HIGH = 2'b10,
        S_FALL = 2'b11
    } irig_state_t;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_NONE = 2'b11
    } irig_mode_t;

endpackage

// File: rtl/irig_edge_chan.sv
// One IRIG channel: synchroniser, glitch filter, edge FSM and high-time counter.
module irig_edge_chan
    import irig_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             irig_in,
    input  logic [1:0]       mode,
    output logic             level,
    output logic             edge_pulse,
    output logic             width_valid,
    output logic [CNT_W-1:0] width,
    output logic [1:0]       state
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0]    FILT_LAST = FW'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FW-1:0]          r_filt_cnt;
    logic                   r_level;
    irig_state_t            r_state;
    irig_state_t            w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_width;
    logic                   r_width_valid;
    logic                   w_sample;

    assign w_sample = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_filt_cnt <= '0;
            r_level    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], irig_in};
            if (w_sample == r_level) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_LAST) begin
                // FILT_LEN-th consecutive differing sample: accept the new level
                r_level    <= ~r_level;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        edge_pulse  = 1'b0;
        case (r_state)
            S_LOW:  w_state_nxt = r_level ? S_RISE : S_LOW;
            S_RISE: begin
                w_state_nxt = r_level ? S_HIGH : S_FALL;
                edge_pulse  = (mode == MODE_RISE) || (mode == MODE_BOTH);
            end
            S_HIGH: w_state_nxt = r_level ? S_HIGH : S_FALL;
            S_FALL: begin
                w_state_nxt = r_level ? S_RISE : S_LOW;
                edge_pulse  = (mode == MODE_FALL) || (mode == MODE_BOTH);
            end
            default: w_state_nxt = S_LOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_width       <= '0;
            r_width_valid <= 1'b0;
        end else begin
            r_width_valid <= 1'b0;
            case (r_state)
                S_RISE: r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                S_HIGH: if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
                S_FALL: begin
                    r_width       <= r_cnt;
                    r_width_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign level       = r_level;
    assign width       = r_width;
    assign width_valid = r_width_valid;
    assign state       = r_state;

endmodule

// File: rtl/irig_edge_meas.sv
// Multi-channel IRIG conditioner: one irig_edge_chan per input, buses packed per channel.
module irig_edge_meas
    import irig_pkg::*;
#(
    parameter int CHANNELS    = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       irig_in,
    input  logic [1:0]                mode,
    output logic [CHANNELS-1:0]       level,
    output logic [CHANNELS-1:0]       edge_pulse,
    output logic [CHANNELS-1:0]       width_valid,
    output logic [CHANNELS*CNT_W-1:0] width,
    output logic [2*CHANNELS-1:0]     state_vec
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        irig_edge_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN   (FILT_LEN),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .irig_in    (irig_in[g]),
            .mode       (mode),
            .level      (level[g]),
            .edge_pulse (edge_pulse[g]),
            .width_valid(width_valid[g]),
            .width      (width[g*CNT_W +: CNT_W]),
            .state      (state_vec[2*g +: 2])
        );
    end

endmodule

// File: tb/tb_irig_edge_meas.sv
// Directed bench for irig_edge_meas: 2 channels, 2 sync stages, FILT_LEN 3, 8-bit widths.
module tb_irig_edge_meas;

    localparam int CH = 2;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH-1:0]     irig_in;
    logic [1:0]        mode;
    logic [CH-1:0]     level;
    logic [CH-1:0]     edge_pulse;
    logic [CH-1:0]     width_valid;
    logic [CH*CW-1:0]  width;
    logic [2*CH-1:0]   state_vec;

    irig_edge_meas #(
        .CHANNELS   (CH),
        .SYNC_STAGES(2),
        .FILT_LEN   (3),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irig_in    (irig_in),
        .mode       (mode),
        .level      (level),
        .edge_pulse (edge_pulse),
        .width_valid(width_valid),
        .width      (width),
        .state_vec  (state_vec)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int t0;

    // Event history gathered on the falling edge, one writer per array.
    int ep_cnt [CH] = '{default: 0};
    int ep_last[CH] = '{default: 0};
    int ep_prev[CH] = '{default: 0};
    int wv_cnt [CH] = '{default: 0};
    int wv_last[CH] = '{default: 0};
    int lv_cnt [CH] = '{default: 0};
    int sn_cnt [CH] = '{default: 0};
    int b_ep[CH], b_wv[CH], b_lv[CH], b_sn[CH];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (edge_pulse[c]) begin
                ep_prev[c] = ep_last[c];
                ep_last[c] = cyc;
                ep_cnt[c]++;
            end
            if (width_valid[c]) begin
                wv_last[c] = cyc;
                wv_cnt[c]++;
            end
            if (level[c]) lv_cnt[c]++;
            if (state_vec[2*c +: 2] != 2'b00) sn_cnt[c]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic snap();
        for (int c = 0; c < CH; c++) begin
            b_ep[c] = ep_cnt[c];
            b_wv[c] = wv_cnt[c];
            b_lv[c] = lv_cnt[c];
            b_sn[c] = sn_cnt[c];
        end
    endtask

    // Raise the channels in m for h cycles; t0 is the edge that captures the rise.
    task automatic drive_hi(input logic [CH-1:0] m, input int h);
        @(negedge clk);
        irig_in = m;
        t0 = cyc + 1;
        repeat (h) @(negedge clk);
        irig_in = '0;
    endtask

    initial begin
        rst_n   = 1'b0;
        irig_in = '0;
        mode    = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_state", 32'(state_vec), 32'd0);
        check("rst_width", 32'(width), 32'd0);
        check("rst_edge", 32'(edge_pulse), 32'd0);
        check("rst_wvalid", 32'(width_valid), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single 20-cycle pulse, rising edges only
        snap();
        drive_hi(2'b01, 20);
        repeat (12) @(negedge clk);
        check("p20_ep_cnt", 32'(ep_cnt[0] - b_ep[0]), 32'd1);
        check("p20_ep_lat", 32'(ep_last[0] - t0), 32'd5);
        check("p20_wv_cnt", 32'(wv_cnt[0] - b_wv[0]), 32'd1);
        check("p20_wv_lat", 32'(wv_last[0] - t0), 32'd26);
        check("p20_width", 32'(width[0 +: CW]), 32'd20);
        check("p20_ch1_ep", 32'(ep_cnt[1] - b_ep[1]), 32'd0);
        check("p20_ch1_wv", 32'(wv_cnt[1] - b_wv[1]), 32'd0);

        // 2-cycle glitch is rejected
        snap();
        drive_hi(2'b01, 2);
        repeat (12) @(negedge clk);
        check("gl_level", 32'(lv_cnt[0] - b_lv[0]), 32'd0);
        check("gl_ep", 32'(ep_cnt[0] - b_ep[0]), 32'd0);
        check("gl_wv", 32'(wv_cnt[0] - b_wv[0]), 32'd0);
        check("gl_state", 32'(sn_cnt[0] - b_sn[0]), 32'd0);

        // Both edges
        mode = 2'b10;
        snap();
        drive_hi(2'b01, 10);
        repeat (12) @(negedge clk);
        check("both_ep_cnt", 32'(ep_cnt[0] - b_ep[0]), 32'd2);
        check("both_spacing", 32'(ep_last[0] - ep_prev[0]), 32'd10);
        check("both_fall_lat", 32'(ep_last[0] - t0), 32'd15);
        check("both_width", 32'(width[0 +: CW]), 32'd10);

        // Falling edge only
        mode = 2'b01;
        snap();
        drive_hi(2'b01, 10);
        repeat (12) @(negedge clk);
        check("fall_ep_cnt", 32'(ep_cnt[0] - b_ep[0]), 32'd1);
        check("fall_ep_lat", 32'(ep_last[0] - t0), 32'd15);

        // No edges, width still measured
        mode = 2'b11;
        snap();
        drive_hi(2'b01, 7);
        repeat (12) @(negedge clk);
        check("none_ep_cnt", 32'(ep_cnt[0] - b_ep[0]), 32'd0);
        check("none_wv_cnt", 32'(wv_cnt[0] - b_wv[0]), 32'd1);
        check("none_width", 32'(width[0 +: CW]), 32'd7);

        // Saturation
        mode = 2'b00;
        snap();
        drive_hi(2'b01, 300);
        repeat (12) @(negedge clk);
        check("sat_width", 32'(width[0 +: CW]), 32'd255);
        check("sat_wv_cnt", 32'(wv_cnt[0] - b_wv[0]), 32'd1);

        // Simultaneous rise, ch1 falls 4 cycles after ch0
        snap();
        @(negedge clk);
        irig_in = 2'b11;
        t0 = cyc + 1;
        repeat (10) @(negedge clk);
        irig_in = 2'b10;
        repeat (4) @(negedge clk);
        irig_in = 2'b00;
        repeat (12) @(negedge clk);
        check("dual_ep0", 32'(ep_cnt[0] - b_ep[0]), 32'd1);
        check("dual_ep1", 32'(ep_cnt[1] - b_ep[1]), 32'd1);
        check("dual_same_cyc", 32'(ep_last[1] - ep_last[0]), 32'd0);
        check("dual_width0", 32'(width[0 +: CW]), 32'd10);
        check("dual_width1", 32'(width[CW +: CW]), 32'd14);
        check("dual_wv_gap", 32'(wv_last[1] - wv_last[0]), 32'd4);

        // Reset while ch0 is in S_HIGH
        @(negedge clk);
        irig_in = 2'b01;
        repeat (10) @(negedge clk);
        check("mid_state_high", 32'(state_vec[1:0]), 32'd2);
        snap();
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(state_vec), 32'd0);
        check("mid_rst_width", 32'(width), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc + 1;
        repeat (10) @(negedge clk);
        check("mid_wv_none", 32'(wv_cnt[0] - b_wv[0]), 32'd0);
        check("mid_reep_cnt", 32'(ep_cnt[0] - b_ep[0]), 32'd1);
        check("mid_reep_lat", 32'(ep_last[0] - t0), 32'd5);
        irig_in = 2'b00;
        repeat (12) @(negedge clk);
        check("mid_wv_after", 32'(wv_cnt[0] - b_wv[0]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
